// File: rtl/uart_rx_byte_fifo.sv
// ---------------------------------------------------------------------------
// UartRxByteFifo (module uart_rx_byte_fifo)
//
// Receive-side byte buffer between the UART RX deserializer and the frame
// parser. First-word-fall-through: the head byte is always presented on
// rx_fifo_data_o while rx_fifo_empty_o is low, and the parser consumes it
// with rx_fifo_rd_en_i. Adds sticky overflow/underflow flags, a saturating
// drop counter and an inter-byte idle timeout pulse.
//
// Ports
//   clk_i              system clock
//   rst_i              synchronous reset, active-high
//   rx_data_i    [7:0] byte from UART RX
//   rx_valid_i         one-cycle strobe qualifying rx_data_i
//   rx_fifo_rd_en_i    parser pop request
//   flush_i            discard all contents (synchronous)
//   clear_flags_i      clear overflow, underflow and overflow_count
//   rx_fifo_data_o     head byte, valid only while !rx_fifo_empty_o
//   rx_fifo_empty_o    occupancy is zero
//   rx_fifo_full_o     occupancy equals DEPTH
//   rx_fifo_count_o    occupancy, $clog2(DEPTH+1) bits
//   overflow_o         sticky: a byte was dropped
//   underflow_o        sticky: pop attempted while empty
//   overflow_count_o   dropped bytes, saturates at 8'hFF
//   idle_timeout_o     one-cycle pulse TIMEOUT_CYCLES clocks after last push
// ---------------------------------------------------------------------------
module uart_rx_byte_fifo #(
  parameter int DEPTH          = 64,
  parameter int TIMEOUT_CYCLES = 32768
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  input  logic                       rx_fifo_rd_en_i,
  input  logic                       flush_i,
  input  logic                       clear_flags_i,
  output logic [7:0]                 rx_fifo_data_o,
  output logic                       rx_fifo_empty_o,
  output logic                       rx_fifo_full_o,
  output logic [$clog2(DEPTH+1)-1:0] rx_fifo_count_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  output logic [7:0]                 overflow_count_o,
  output logic                       idle_timeout_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [7:0]    mem [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic [7:0]    ovfCount_q, ovfCount_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          armed_q, armed_d;
  logic          timeout_q, timeout_d;

  logic          isEmpty;
  logic          isFull;
  logic          doPop;
  logic          doPush;
  logic          dropEvt;
  logic          underEvt;

  // Decide what happens at the coming edge. Flush overrides every push, pop
  // and flag event. A full FIFO still accepts a push when the same cycle pops,
  // because the pop frees the slot; an empty FIFO accepts the push but ignores
  // the pop, which counts as an underflow.
  always_comb begin
    isEmpty  = (count_q == '0);
    isFull   = (count_q == CW'(DEPTH));
    doPop    = rx_fifo_rd_en_i && !isEmpty && !flush_i;
    doPush   = rx_valid_i && (!isFull || (rx_fifo_rd_en_i && !isEmpty)) && !flush_i;
    dropEvt  = rx_valid_i && isFull && !rx_fifo_rd_en_i && !flush_i;
    underEvt = rx_fifo_rd_en_i && isEmpty && !flush_i;

    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    ovfCount_d  = ovfCount_q;
    timer_d     = timer_q;
    armed_d     = armed_q;
    timeout_d   = 1'b0;

    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) begin
        wrPtr_d = wrPtr_q + AW'(1);
      end
      if (doPop) begin
        rdPtr_d = rdPtr_q + AW'(1);
      end
      if (doPush && !doPop) begin
        count_d = count_q + CW'(1);
      end else if (doPop && !doPush) begin
        count_d = count_q - CW'(1);
      end
    end

    // A clear in the same cycle as a new event leaves the event recorded,
    // so the clear is applied first and the event layered on top.
    if (clear_flags_i) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      ovfCount_d  = 8'h00;
    end
    if (dropEvt) begin
      overflow_d = 1'b1;
      if (ovfCount_d != 8'hFF) begin
        ovfCount_d = ovfCount_d + 8'd1;
      end
    end
    if (underEvt) begin
      underflow_d = 1'b1;
    end

    // The timer disarms when it expires, so it never needs to wrap. An
    // accepted push on the expiry edge restarts it and swallows the pulse.
    if (flush_i) begin
      armed_d = 1'b0;
    end else if (doPush) begin
      timer_d = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        timeout_d = 1'b1;
        armed_d   = 1'b0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      ovfCount_q  <= 8'h00;
      timer_q     <= '0;
      armed_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      ovfCount_q  <= ovfCount_d;
      timer_q     <= timer_d;
      armed_q     <= armed_d;
      timeout_q   <= timeout_d;
    end
  end

  // Storage array has no reset; a stray write during reset is harmless
  // because the pointers and count restart from zero.
  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem[wrPtr_q] <= rx_data_i;
    end
  end

  // First-word-fall-through head and status outputs.
  always_comb begin
    rx_fifo_data_o   = mem[rdPtr_q];
    rx_fifo_empty_o  = isEmpty;
    rx_fifo_full_o   = isFull;
    rx_fifo_count_o  = count_q;
    overflow_o       = overflow_q;
    underflow_o      = underflow_q;
    overflow_count_o = ovfCount_q;
    idle_timeout_o   = timeout_q;
  end

endmodule
